// File: rtl/plab4_net_term_eject_tp.sv
// ----------------------------------------------------------------------------
// plab4_net_term_eject_tp
//
// Terminal-side ejection endpoint for one port of the timing-protected ring.
// Each message delivered by the router is steered by the active security
// domain into one of two private FIFOs (D1 = domain 0, D2 = domain 1). Each
// FIFO drains to its own consumer interface.
//
// net_rdy depends only on the active domain and that domain's registered
// count. No consumer ready signal feeds it, so one domain's consumer cannot
// modulate the timing seen by the other domain.
//
// Messages whose dest field differs from p_router_id are accepted and then
// dropped. This sets the sticky err flag of the active domain.
//
// Ports:
//   clk, reset (async, active-low)
//   domain                        active domain (0 = D1, 1 = D2)
//   net_val / net_rdy / net_msg   router terminal-output channel
//   out_val_dk / out_rdy_dk / out_msg_dk   per-domain consumer interface
//   err_d0 / err_d1               sticky misroute flags
//   cnt_d0 / cnt_d1               saturating dequeue counters, present only
//                                 when PLAB4_NET_TERM_EJECT_STATS_EN is defined
//
// Message layout: {dest, src, opaque, payload}, so dest = msg[m-1 -: s].
// ----------------------------------------------------------------------------
module plab4_net_term_eject_tp #(
    parameter int p_payload_nbits = 32,
    parameter int p_opaque_nbits  = 3,
    parameter int p_srcdest_nbits = 3,
    parameter int p_router_id     = 0,
    parameter int p_depth         = 2,
    localparam int m = p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         domain,
    input  logic         net_val,
    output logic         net_rdy,
    input  logic [m-1:0] net_msg,
    output logic         out_val_d0,
    input  logic         out_rdy_d0,
    output logic [m-1:0] out_msg_d0,
    output logic         out_val_d1,
    input  logic         out_rdy_d1,
    output logic [m-1:0] out_msg_d1,
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
    output logic [15:0]  cnt_d0,
    output logic [15:0]  cnt_d1,
`endif
    output logic         err_d0,
    output logic         err_d1
);

    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth + 1);

    // Pointer advance with explicit wrap from p_depth-1 back to 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(p_depth - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [m-1:0]  mem_q     [2][p_depth];
    logic [PW-1:0] wr_ptr_q  [2];
    logic [PW-1:0] wr_ptr_d  [2];
    logic [PW-1:0] rd_ptr_q  [2];
    logic [PW-1:0] rd_ptr_d  [2];
    logic [CW-1:0] count_q   [2];
    logic [CW-1:0] count_d   [2];
    logic          err_q     [2];
    logic          err_d     [2];
    logic          enq_s     [2];
    logic          deq_s     [2];
    logic          out_rdy_s [2];
    logic          accept_s;
    logic          dest_ok_s;
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
    logic [15:0]   cnt_q     [2];
    logic [15:0]   cnt_d     [2];
`endif

    assign out_rdy_s[0] = out_rdy_d0;
    assign out_rdy_s[1] = out_rdy_d1;

    // Handshake decode and next-state computation for both domain FIFOs.
    always_comb begin
        net_rdy   = (count_q[domain] != CW'(p_depth));
        accept_s  = net_val && net_rdy;
        dest_ok_s = (net_msg[m-1 -: p_srcdest_nbits] == p_srcdest_nbits'(p_router_id));
        for (int k = 0; k < 2; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            count_d[k]  = count_q[k];
            err_d[k]    = err_q[k];
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
            cnt_d[k]    = cnt_q[k];
`endif
            // A misrouted message still completes the handshake but is never stored.
            enq_s[k] = accept_s && (domain == 1'(k)) && dest_ok_s;
            deq_s[k] = (count_q[k] != {CW{1'b0}}) && out_rdy_s[k];

            if (accept_s && (domain == 1'(k)) && !dest_ok_s) begin
                err_d[k] = 1'b1;
            end else begin
                err_d[k] = err_q[k];
            end

            if (enq_s[k]) begin
                wr_ptr_d[k] = ptr_inc(wr_ptr_q[k]);
            end else begin
                wr_ptr_d[k] = wr_ptr_q[k];
            end

            if (deq_s[k]) begin
                rd_ptr_d[k] = ptr_inc(rd_ptr_q[k]);
            end else begin
                rd_ptr_d[k] = rd_ptr_q[k];
            end

            case ({enq_s[k], deq_s[k]})
                2'b10:   count_d[k] = count_q[k] + CW'(1);
                2'b01:   count_d[k] = count_q[k] - CW'(1);
                default: count_d[k] = count_q[k];
            endcase

`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
            if (deq_s[k] && (cnt_q[k] != 16'hFFFF)) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end else begin
                cnt_d[k] = cnt_q[k];
            end
`endif
        end
    end

    // Pointer, count, error and statistics state with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= {PW{1'b0}};
                rd_ptr_q[k] <= {PW{1'b0}};
                count_q[k]  <= {CW{1'b0}};
                err_q[k]    <= 1'b0;
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
                cnt_q[k]    <= 16'd0;
`endif
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                count_q[k]  <= count_d[k];
                err_q[k]    <= err_d[k];
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
                cnt_q[k]    <= cnt_d[k];
`endif
            end
        end
    end

    // FIFO storage. It needs no reset because validity is carried by count_q.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (enq_s[k]) begin
                mem_q[k][wr_ptr_q[k]] <= net_msg;
            end
        end
    end

    assign out_val_d0 = (count_q[0] != {CW{1'b0}});
    assign out_val_d1 = (count_q[1] != {CW{1'b0}});
    assign out_msg_d0 = mem_q[0][rd_ptr_q[0]];
    assign out_msg_d1 = mem_q[1][rd_ptr_q[1]];
    assign err_d0     = err_q[0];
    assign err_d1     = err_q[1];
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
    assign cnt_d0     = cnt_q[0];
    assign cnt_d1     = cnt_q[1];
`endif

endmodule

// File: tb/tb_plab4_net_term_eject_tp.sv
module tb_plab4_net_term_eject_tp;

    localparam int PN    = 32;
    localparam int ON    = 3;
    localparam int SN    = 3;
    localparam int RID   = 0;
    localparam int DEPTH = 2;
    localparam int M     = PN + ON + 2 * SN;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         domain = 1'b0;
    logic         net_val = 1'b0;
    logic         net_rdy;
    logic [M-1:0] net_msg = '0;
    logic         out_val_d0, out_val_d1;
    logic         out_rdy_d0 = 1'b0, out_rdy_d1 = 1'b0;
    logic [M-1:0] out_msg_d0, out_msg_d1;
    logic         err_d0, err_d1;
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
    logic [15:0]  cnt_d0, cnt_d1;
`endif

    plab4_net_term_eject_tp #(
        .p_payload_nbits (PN),
        .p_opaque_nbits  (ON),
        .p_srcdest_nbits (SN),
        .p_router_id     (RID),
        .p_depth         (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .domain     (domain),
        .net_val    (net_val),
        .net_rdy    (net_rdy),
        .net_msg    (net_msg),
        .out_val_d0 (out_val_d0),
        .out_rdy_d0 (out_rdy_d0),
        .out_msg_d0 (out_msg_d0),
        .out_val_d1 (out_val_d1),
        .out_rdy_d1 (out_rdy_d1),
        .out_msg_d1 (out_msg_d1),
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
        .cnt_d0     (cnt_d0),
        .cnt_d1     (cnt_d1),
`endif
        .err_d0     (err_d0),
        .err_d1     (err_d1)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per domain plus sticky flags and counters.
    logic [M-1:0] q0[$];
    logic [M-1:0] q1[$];
    logic         m_err0 = 1'b0, m_err1 = 1'b0;
    int           m_cnt0 = 0, m_cnt1 = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [M-1:0] mk(input int dest, input logic [PN-1:0] pay);
        logic [SN-1:0] d;
        logic [SN-1:0] s;
        logic [ON-1:0] o;
        d = SN'(dest);
        s = SN'($urandom_range(0, 7));
        o = ON'($urandom_range(0, 7));
        return {d, s, o, pay};
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_err0 = 1'b0;
        m_err1 = 1'b0;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    // Compare all visible outputs against the model for the current inputs.
    task automatic check_outputs();
        int sz;
        sz = (domain == 1'b0) ? q0.size() : q1.size();
        chk("net_rdy", 64'(net_rdy), 64'(sz != DEPTH));
        chk("out_val_d0", 64'(out_val_d0), 64'(q0.size() != 0));
        chk("out_val_d1", 64'(out_val_d1), 64'(q1.size() != 0));
        if (q0.size() != 0) chk("out_msg_d0", 64'(out_msg_d0), 64'(q0[0]));
        if (q1.size() != 0) chk("out_msg_d1", 64'(out_msg_d1), 64'(q1[0]));
        chk("err_d0", 64'(err_d0), 64'(m_err0));
        chk("err_d1", 64'(err_d1), 64'(m_err1));
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
        chk("cnt_d0", 64'(cnt_d0), 64'(m_cnt0));
        chk("cnt_d1", 64'(cnt_d1), 64'(m_cnt1));
`endif
    endtask

    // One clock cycle: apply inputs, check, advance the model, cross the edge.
    task automatic cyc(input logic dom, input logic nv, input logic [M-1:0] msg,
                       input logic r0, input logic r1);
        logic acc;
        logic dq0;
        logic dq1;
        domain     = dom;
        net_val    = nv;
        net_msg    = msg;
        out_rdy_d0 = r0;
        out_rdy_d1 = r1;
        #1;
        check_outputs();
        acc = nv && (((dom == 1'b0) ? q0.size() : q1.size()) != DEPTH);
        dq0 = r0 && (q0.size() != 0);
        dq1 = r1 && (q1.size() != 0);
        if (dq0) begin
            void'(q0.pop_front());
            if (m_cnt0 != 65535) m_cnt0++;
        end
        if (dq1) begin
            void'(q1.pop_front());
            if (m_cnt1 != 65535) m_cnt1++;
        end
        if (acc) begin
            if (msg[M-1 -: SN] == SN'(RID)) begin
                if (dom == 1'b0) q0.push_back(msg);
                else             q1.push_back(msg);
            end else begin
                if (dom == 1'b0) m_err0 = 1'b1;
                else             m_err1 = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, observed while reset is held.
        #2;
        chk("rst_net_rdy", 64'(net_rdy), 64'(1));
        chk("rst_out_val_d0", 64'(out_val_d0), 64'(0));
        chk("rst_out_val_d1", 64'(out_val_d1), 64'(0));
        chk("rst_err_d0", 64'(err_d0), 64'(0));
        chk("rst_err_d1", 64'(err_d1), 64'(0));
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single A5 message into D1, visible one cycle later, held, then drained.
        cyc(1'b0, 1'b1, mk(RID, 32'h000000A5), 1'b0, 1'b0);
        chk("a5_payload", 64'(out_msg_d0[PN-1:0]), 64'(32'hA5));
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Fill D2, check full back-pressure, then switch to D1 combinationally.
        cyc(1'b1, 1'b1, mk(RID, 32'h11111111), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, mk(RID, 32'h22222222), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, mk(RID, 32'h33333333), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        // Full D2 with a simultaneous dequeue: still not ready this cycle.
        cyc(1'b1, 1'b1, mk(RID, 32'h44444444), 1'b0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Misrouted message on D1: accepted, dropped, err_d0 sticky.
        cyc(1'b0, 1'b1, mk(RID + 1, 32'hBADBAD00), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Five messages streamed through D1 with the consumer always ready.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, mk(RID, 32'(32'hC0DE0000 + i)), 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
`ifdef PLAB4_NET_TERM_EJECT_STATS_EN
        chk("cnt_d0_after_stream", 64'(cnt_d0), 64'(6));
`endif

        // Randomized traffic; mostly correctly addressed messages.
        for (int i = 0; i < 600; i++) begin
            logic [M-1:0] msg;
            int dst;
            dst = ($urandom_range(0, 15) == 0) ? RID + 1 + $urandom_range(0, 5) : RID;
            msg = mk(dst, $urandom);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), msg,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        end

        // Mid-stream reset with one message in D1.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, mk(RID, 32'h5A5A5A5A), 1'b0, 1'b0);
        chk("pre_rst_val_d0", 64'(out_val_d0), 64'(1));
        net_val = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_out_val_d0", 64'(out_val_d0), 64'(0));
        chk("mid_rst_net_rdy", 64'(net_rdy), 64'(1));
        chk("mid_rst_err_d0", 64'(err_d0), 64'(0));
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, mk(RID, 32'h0000BEEF), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
